// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with a clock-enable prescaler, synchronous load and wrap/terminal-count flags.
// Runs entirely in the clk domain: the prescaler produces a one-cycle enable strobe, not a derived clock.
module updown_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned DIV     = 50_000_000
) (
    input  logic             clk,
    input  logic             Clear_n,
    input  logic             sync_clr,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tick,
    output logic             wrap,
    output logic             tc
);

    localparam int unsigned      PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   Q_LIM  = {1'b0, Q_MAX};

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    mode_e            mode;
    logic [PW-1:0]    pcnt;
    logic             pcnt_last;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign mode      = mode_e'(sel);
    assign pcnt_last = (pcnt == P_LAST);

    // Prescaler free-runs regardless of en; tick is the registered end-of-period strobe.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (sync_clr) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= pcnt_last;
            pcnt <= pcnt_last ? '0 : pcnt + 1'b1;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (en) begin
            case (mode)
                MODE_LOAD: begin
                    // Zero-extended compare keeps the clamp meaningful when MAX_VAL is all ones.
                    q_next = ({1'b0, load_val} > Q_LIM) ? Q_MAX : load_val;
                end
                MODE_DOWN: begin
                    if (tick) begin
                        if (Q == '0) begin
                            q_next    = Q_MAX;
                            wrap_next = 1'b1;
                        end else begin
                            q_next = Q - 1'b1;
                        end
                    end
                end
                MODE_UP: begin
                    if (tick) begin
                        if (Q >= Q_MAX) begin
                            q_next    = '0;
                            wrap_next = 1'b1;
                        end else begin
                            q_next = Q + 1'b1;
                        end
                    end
                end
                default: begin
                    q_next = Q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (sync_clr) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
        end
    end

    assign tc = ((mode == MODE_UP) && (Q == Q_MAX)) || ((mode == MODE_DOWN) && (Q == '0));

endmodule
